// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: the decoded instruction coming out of ID,
// the pipeline control strobes, and the registered copy presented to EX
// together with the interrupt restart PC.
interface id_ex_reg_if #(
    parameter int DW = 32
);
    // Pipeline control strobes
    logic          Stall;
    logic          Flush;
    logic          IntFlush;

    // ID-stage instruction fields
    logic [DW-1:0] PC_D;
    logic [DW-1:0] RD1_D;
    logic [DW-1:0] RD2_D;
    logic [DW-1:0] Imm32_D;
    logic [4:0]    Rs_D;
    logic [4:0]    Rt_D;
    logic [4:0]    Rd_D;
    logic [15:0]   Ctrl_D;
    logic          BD_D;
    logic          Valid_D;

    // EX-stage registered copies
    logic [DW-1:0] PC_E;
    logic [DW-1:0] RD1_E;
    logic [DW-1:0] RD2_E;
    logic [DW-1:0] Imm32_E;
    logic [4:0]    Rs_E;
    logic [4:0]    Rt_E;
    logic [4:0]    Rd_E;
    logic [15:0]   Ctrl_E;
    logic          BD_E;
    logic          Valid_E;

    // Interrupt restart PC for the CP0 EPC write
    logic [DW-1:0] EPC;
    logic          EPCValid;

    // ID/hazard side: drives the instruction and strobes, observes EX copy
    modport master (
        output Stall, Flush, IntFlush,
        output PC_D, RD1_D, RD2_D, Imm32_D, Rs_D, Rt_D, Rd_D, Ctrl_D, BD_D, Valid_D,
        input  PC_E, RD1_E, RD2_E, Imm32_E, Rs_E, Rt_E, Rd_E, Ctrl_E, BD_E, Valid_E,
        input  EPC, EPCValid
    );

    // Pipeline register side
    modport slave (
        input  Stall, Flush, IntFlush,
        input  PC_D, RD1_D, RD2_D, Imm32_D, Rs_D, Rt_D, Rd_D, Ctrl_D, BD_D, Valid_D,
        output PC_E, RD1_E, RD2_E, Imm32_E, Rs_E, Rt_E, Rd_E, Ctrl_E, BD_E, Valid_E,
        output EPC, EPCValid
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the five-stage MIPS core. Holds on a load-use
// stall, inserts a bubble on branch/jump flush, and on an accepted
// interrupt kills the stage while recording the restart PC for CP0 EPC.
// Action priority on each edge: IntFlush > Flush > Stall > load.
module id_ex_reg #(
    parameter int DW = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    id_ex_reg_if.slave bus
);

    localparam logic [DW-1:0] INSTR_BYTES = DW'(4);

    logic [DW-1:0] restart_pc;

    // Restart address: the EX instruction if real (its branch when in a delay slot), else the ID instruction likewise
    always_comb begin
        restart_pc = bus.PC_D;
        if (bus.Valid_E) begin
            if (bus.BD_E) begin
                restart_pc = bus.PC_E - INSTR_BYTES;
            end else begin
                restart_pc = bus.PC_E;
            end
        end else if (bus.BD_D) begin
            restart_pc = bus.PC_D - INSTR_BYTES;
        end
    end

    // Stage register: bubble on either flush (PC kept only for branch flush), hold on stall, else load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.PC_E    <= '0;
            bus.RD1_E   <= '0;
            bus.RD2_E   <= '0;
            bus.Imm32_E <= '0;
            bus.Rs_E    <= '0;
            bus.Rt_E    <= '0;
            bus.Rd_E    <= '0;
            bus.Ctrl_E  <= '0;
            bus.BD_E    <= 1'b0;
            bus.Valid_E <= 1'b0;
        end else if (bus.IntFlush || bus.Flush) begin
            bus.PC_E    <= bus.IntFlush ? '0 : bus.PC_D;
            bus.RD1_E   <= '0;
            bus.RD2_E   <= '0;
            bus.Imm32_E <= '0;
            bus.Rs_E    <= '0;
            bus.Rt_E    <= '0;
            bus.Rd_E    <= '0;
            bus.Ctrl_E  <= '0;
            bus.BD_E    <= 1'b0;
            bus.Valid_E <= 1'b0;
        end else if (!bus.Stall) begin
            bus.PC_E    <= bus.PC_D;
            bus.RD1_E   <= bus.RD1_D;
            bus.RD2_E   <= bus.RD2_D;
            bus.Imm32_E <= bus.Imm32_D;
            bus.Rs_E    <= bus.Rs_D;
            bus.Rt_E    <= bus.Rt_D;
            bus.Rd_E    <= bus.Rd_D;
            bus.Ctrl_E  <= bus.Ctrl_D;
            bus.BD_E    <= bus.BD_D;
            bus.Valid_E <= bus.Valid_D;
        end
    end

    // EPC capture with a one-cycle valid pulse per accepted interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.EPC      <= '0;
            bus.EPCValid <= 1'b0;
        end else begin
            bus.EPCValid <= bus.IntFlush;
            if (bus.IntFlush) begin
                bus.EPC <= restart_pc;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: a table of {strobes, ID inputs, expected EX
// outputs, expected EPC} rows stepped one edge at a time through a
// scoreboard queue, plus hand-written asynchronous reset sequences.
module tb_id_ex_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic        bd;
        logic        valid;
    } stage_t;

    typedef struct packed {
        stage_t      s;
        logic [31:0] epc;
        logic        epcv;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        intf;
        stage_t      din;
        stage_t      dout;
        logic [31:0] epc;
        logic        epcv;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t tbl[$];

    id_ex_reg_if #(.DW(32)) bus();

    id_ex_reg #(.DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    function automatic stage_t rec(input logic [31:0] pc, input logic [31:0] rd1,
                                   input logic [31:0] rd2, input logic [31:0] imm,
                                   input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [15:0] ctrl, input logic bd, input logic valid);
        stage_t r;
        r.pc = pc; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm;
        r.rs = rs; r.rt = rt; r.rd = rd; r.ctrl = ctrl; r.bd = bd; r.valid = valid;
        return r;
    endfunction

    function automatic stage_t bubble(input logic [31:0] pc);
        return rec(pc, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t mkVec(input logic s, input logic f, input logic i,
                                   input stage_t din, input stage_t dout,
                                   input logic [31:0] epc, input logic epcv);
        vec_t v;
        v.stall = s; v.flush = f; v.intf = i;
        v.din = din; v.dout = dout; v.epc = epc; v.epcv = epcv;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic driveInputs(input logic s, input logic f, input logic i, input stage_t d);
        bus.Stall    = s;
        bus.Flush    = f;
        bus.IntFlush = i;
        bus.PC_D     = d.pc;
        bus.RD1_D    = d.rd1;
        bus.RD2_D    = d.rd2;
        bus.Imm32_D  = d.imm;
        bus.Rs_D     = d.rs;
        bus.Rt_D     = d.rt;
        bus.Rd_D     = d.rd;
        bus.Ctrl_D   = d.ctrl;
        bus.BD_D     = d.bd;
        bus.Valid_D  = d.valid;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        driveInputs(v.stall, v.flush, v.intf, v.din);
        e.s    = v.dout;
        e.epc  = v.epc;
        e.epcv = v.epcv;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
        end else begin
            e = sb.pop_front();
            cmp("PC_E",     bus.PC_E,            e.s.pc);
            cmp("RD1_E",    bus.RD1_E,           e.s.rd1);
            cmp("RD2_E",    bus.RD2_E,           e.s.rd2);
            cmp("Imm32_E",  bus.Imm32_E,         e.s.imm);
            cmp("Rs_E",     32'(bus.Rs_E),       32'(e.s.rs));
            cmp("Rt_E",     32'(bus.Rt_E),       32'(e.s.rt));
            cmp("Rd_E",     32'(bus.Rd_E),       32'(e.s.rd));
            cmp("Ctrl_E",   32'(bus.Ctrl_E),     32'(e.s.ctrl));
            cmp("BD_E",     32'(bus.BD_E),       32'(e.s.bd));
            cmp("Valid_E",  32'(bus.Valid_E),    32'(e.s.valid));
            cmp("EPC",      bus.EPC,             e.epc);
            cmp("EPCValid", 32'(bus.EPCValid),   32'(e.epcv));
        end
    endtask

    task automatic stepRow(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic expectZeroNow();
        sb.push_back('0);
        checkOutput();
    endtask

    // Main sequence: reset state, vector table, then mid-run reset cases
    initial begin
        stage_t a, b, c, c2, d, e, f, g, h, i0, j, k, l, m, r;

        a  = rec(32'h00400004, 32'h11111111, 32'h22222222, 32'hFFFF8000, 5'd1,  5'd2,  5'd3,  16'h0243, 1'b0, 1'b1);
        b  = rec(32'h00400008, 32'h33333333, 32'h44444444, 32'h00001234, 5'd4,  5'd5,  5'd6,  16'hF021, 1'b1, 1'b1);
        c  = rec(32'h0040000C, 32'h55555555, 32'h66666666, 32'h0000ABCD, 5'd7,  5'd8,  5'd9,  16'h0C3F, 1'b0, 1'b1);
        c2 = rec(32'h00400010, 32'h77777777, 32'h88888888, 32'h12340000, 5'd10, 5'd11, 5'd12, 16'h0002, 1'b1, 1'b0);
        d  = rec(32'h00400020, 32'h00000005, 32'h00000006, 32'h00000007, 5'd7,  5'd8,  5'd9,  16'h0FFF, 1'b1, 1'b1);
        e  = rec(32'h00400030, 32'h0000000A, 32'h0000000B, 32'h0000000C, 5'd10, 5'd11, 5'd12, 16'h0021, 1'b0, 1'b1);
        f  = rec(32'h00400034, 32'h0000000D, 32'h0000000E, 32'h0000000F, 5'd13, 5'd14, 5'd15, 16'h0005, 1'b1, 1'b1);
        g  = rec(32'h00400034, 32'h00000010, 32'h00000020, 32'h00000030, 5'd16, 5'd17, 5'd18, 16'h0001, 1'b1, 1'b1);
        h  = rec(32'h00000000, 32'h00000040, 32'h00000050, 32'h00000060, 5'd19, 5'd20, 5'd21, 16'h0003, 1'b1, 1'b1);
        i0 = rec(32'h00400040, 32'h00000070, 32'h00000080, 32'h00000090, 5'd22, 5'd23, 5'd24, 16'h0041, 1'b0, 1'b1);
        j  = rec(32'h00400040, 32'h000000A0, 32'h000000B0, 32'h000000C0, 5'd25, 5'd26, 5'd27, 16'h0081, 1'b1, 1'b1);
        k  = rec(32'h00400050, 32'h000000D0, 32'h000000E0, 32'h000000F0, 5'd28, 5'd29, 5'd30, 16'h0101, 1'b1, 1'b1);
        l  = rec(32'h00400060, 32'h00000100, 32'h00000200, 32'h00000300, 5'd31, 5'd1,  5'd2,  16'h0201, 1'b0, 1'b1);
        m  = rec(32'h00400070, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0000FFFF, 5'd3,  5'd4,  5'd5,  16'hA7FF, 1'b0, 1'b1);
        r  = rec(32'h00400010, 32'h00000099, 32'h000000AA, 32'h000000BB, 5'd6,  5'd7,  5'd8,  16'h0243, 1'b0, 1'b1);

        // load, then stall three cycles with changing inputs, then resume
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b0, a,  a,  32'h0, 1'b0));
        tbl.push_back(mkVec(1'b1, 1'b0, 1'b0, b,  a,  32'h0, 1'b0));
        tbl.push_back(mkVec(1'b1, 1'b0, 1'b0, c,  a,  32'h0, 1'b0));
        tbl.push_back(mkVec(1'b1, 1'b0, 1'b0, c2, a,  32'h0, 1'b0));
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b0, b,  b,  32'h0, 1'b0));
        // flush beats stall; PC still loads
        tbl.push_back(mkVec(1'b1, 1'b1, 1'b0, d,  bubble(32'h00400020), 32'h0, 1'b0));
        // interrupt on a normal instruction
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b0, e,  e,  32'h0, 1'b0));
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b1, f,  bubble(32'h0), 32'h00400030, 1'b1));
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b0, g,  g,  32'h00400030, 1'b0));
        // interrupt in a delay slot, stall asserted too
        tbl.push_back(mkVec(1'b1, 1'b0, 1'b1, f,  bubble(32'h0), 32'h00400030, 1'b1));
        // delay slot at PC 0 wraps
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b0, h,  h,  32'h00400030, 1'b0));
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b1, a,  bubble(32'h0), 32'hFFFFFFFC, 1'b1));
        // back-to-back interrupts on a bubble: restart from the ID instruction
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b1, i0, bubble(32'h0), 32'h00400040, 1'b1));
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b1, j,  bubble(32'h0), 32'h0040003C, 1'b1));
        // plain flush keeps EPC, then interrupt together with flush
        tbl.push_back(mkVec(1'b0, 1'b1, 1'b0, k,  bubble(32'h00400050), 32'h0040003C, 1'b0));
        tbl.push_back(mkVec(1'b0, 1'b1, 1'b1, l,  bubble(32'h0), 32'h00400060, 1'b1));
        // stall holds the bubble and EPC, then load
        tbl.push_back(mkVec(1'b1, 1'b0, 1'b0, m,  bubble(32'h0), 32'h00400060, 1'b0));
        tbl.push_back(mkVec(1'b0, 1'b0, 1'b0, m,  m,  32'h00400060, 1'b0));

        driveInputs(1'b0, 1'b0, 1'b0, a);
        #2;
        expectZeroNow();

        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < tbl.size(); n++) begin
            stepRow(tbl[n]);
        end

        // reset dropped between edges clears a loaded stage at once
        stepRow(mkVec(1'b0, 1'b0, 1'b0, r, r, 32'h00400060, 1'b0));
        #2;
        bus.Stall = 1'b1;
        rst_n = 1'b0;
        #1;
        expectZeroNow();
        @(posedge clk);
        #1;
        expectZeroNow();
        @(negedge clk);
        rst_n = 1'b1;

        // reset dropped while EPCValid is high clears the pulse and EPC
        stepRow(mkVec(1'b0, 1'b0, 1'b1, a, bubble(32'h0), 32'h00400004, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        expectZeroNow();
        @(negedge clk);
        rst_n = 1'b1;
        stepRow(mkVec(1'b0, 1'b0, 1'b0, a, a, 32'h0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It captures the decoded instruction from the ID stage, including the 32-bit extended immediate, register operands and control bundle, and presents it to the EX stage (ALU operand mux, forwarding unit, interrupt logic). It supports hold (load-use stall), bubble insertion (branch/jump flush) and interrupt flush. On an interrupt flush it records the restart PC for the CP0 EPC write.

## Interface
- `DW`, 32: datapath width (PC, operands, immediate).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `Stall`  in  1  hold current contents (load-use hazard).
- `Flush`  in  1  replace the incoming instruction with a bubble on the next edge.
- `IntFlush`  in  1  interrupt accepted: kill the stage and capture the restart PC.
- `PC_D`  in  DW  PC of the ID instruction.
- `RD1_D`, `RD2_D`  in  DW  register file read data.
- `Imm32_D`  in  DW  extended immediate (zero, sign or LUI form).
- `Rs_D`, `Rt_D`, `Rd_D`  in  5  register specifiers.
- `Ctrl_D`  in  16  control bundle: [0] RegWrite, [1] MemRead, [2] MemWrite, [4:3] MemtoReg, [5] ALUSrc, [9:6] ALUOp, [11:10] RegDst, [15:12] reserved.
- `BD_D`  in  1  the ID instruction sits in a branch delay slot.
- `Valid_D`  in  1  the ID slot holds a real instruction.
- `PC_E`, `RD1_E`, `RD2_E`, `Imm32_E`  out  DW  registered copies.
- `Rs_E`, `Rt_E`, `Rd_E`  out  5  registered copies.
- `Ctrl_E`  out  16  registered control bundle.
- `BD_E`, `Valid_E`  out  1  registered flags.
- `EPC`  out  DW  restart PC captured on IntFlush.
- `EPCValid`  out  1  one-cycle pulse: EPC has been updated.

## Operation
- Each rising edge applies the highest-priority action in this order: IntFlush > Flush > Stall > load.
- **Load** (no control input asserted): every `_E` output takes its `_D` input.
- **Stall**: all `_E` outputs hold their values. EPC holds.
- **Flush** (without IntFlush):
  - Insert a bubble: Ctrl_E = 0, Valid_E = 0, BD_E = 0.
  - PC_E still loads PC_D, so a later interrupt has a restart address.
  - Data fields (RD1/RD2/Imm32/Rs/Rt/Rd) are cleared to 0 so the forwarding unit sees Rs_E = Rt_E = 0.
  - Flush overrides Stall in the same cycle.
- **IntFlush**: insert a bubble exactly as for Flush, then select the restart PC as follows.
  - If Valid_E = 1 and BD_E = 1, restart at PC_E − 4 (re-execute the branch).
  - If Valid_E = 1 and BD_E = 0, restart at PC_E.
  - If Valid_E = 0, restart at PC_D (if BD_D = 1, at PC_D − 4).
  - The selected value is written to EPC and EPCValid pulses high for one cycle.
  - PC_E after an IntFlush is 0.
- EPC arithmetic is modulo 2^DW. The −4 wraps, e.g. 0x00000000 → 0xFFFFFFFC.
- Ctrl_E[15:12] is passed through unmodified on load and cleared on bubble.

## Timing
- Latency: 1 cycle from `_D` inputs to `_E` outputs.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (rst_n = 0, asynchronous): all outputs are 0, including EPC = 0, EPCValid = 0 and Valid_E = 0.
  - Reset takes effect immediately, without waiting for a clock edge, and overrides any in-progress Stall.
  - The first edge after rst_n rises performs a normal prioritized action.
- EPCValid is high only in the cycle after an IntFlush edge. Back-to-back IntFlush gives a pulse on each cycle, and EPC updates on each.
- Stall held for N cycles keeps outputs constant for N cycles. Loading resumes on the first edge with Stall = 0.
- Stall together with IntFlush: IntFlush wins and the bubble is inserted.

## Test plan
- **Reset mid-run**: load PC_D = 0x00400010 and Ctrl_D = 0x0243, then drop rst_n between edges -> all outputs are 0 immediately; EPCValid = 0.
- **Load then stall**: load PC_D = 0x00400004, Imm32_D = 0xFFFF8000, then assert Stall for 3 cycles while the inputs change -> PC_E and Imm32_E hold for 3 cycles, then update on the first free edge.
- **Flush vs Stall**: assert Stall = 1 and Flush = 1 with PC_D = 0x00400020 -> Ctrl_E = 0, Valid_E = 0, Rs_E = 0, PC_E = 0x00400020.
- **Interrupt, normal instruction**: Valid_E = 1, BD_E = 0, PC_E = 0x00400030, then IntFlush -> EPC = 0x00400030; EPCValid pulses for 1 cycle; Ctrl_E = 0.
- **Interrupt in delay slot**: Valid_E = 1, BD_E = 1, PC_E = 0x00400034 -> EPC = 0x00400030. Repeat with PC_E = 0 -> EPC = 0xFFFFFFFC.
- **Interrupt on bubble**: Valid_E = 0, PC_D = 0x00400040, BD_D = 0 -> EPC = 0x00400040. Repeat with BD_D = 1 -> EPC = 0x0040003C.
